// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if -- bundle of the two requester ports (A = CPU, B = DMA)
// and the SRAM-controller command port that sit around ram_arbiter.
//
// Signals:
//   a_*/b_*  : req, wr, byte, addr[17:0], wdata[15:0] toward the arbiter;
//              rdata[15:0], ack, err back to the requester
//   m_*      : addr[17:0], data_in[15:0], rd, wr, byte_op toward the
//              controller; data_out[15:0], done back from it
//
// Modports:
//   master : the arbiter's view (it issues the controller commands)
//   slave  : everything around it (requesters and SRAM controller)
interface ram_arbiter_if;
  logic        a_req;
  logic        a_wr;
  logic        a_byte;
  logic [17:0] a_addr;
  logic [15:0] a_wdata;
  logic [15:0] a_rdata;
  logic        a_ack;
  logic        a_err;

  logic        b_req;
  logic        b_wr;
  logic        b_byte;
  logic [17:0] b_addr;
  logic [15:0] b_wdata;
  logic [15:0] b_rdata;
  logic        b_ack;
  logic        b_err;

  logic [17:0] m_addr;
  logic [15:0] m_data_in;
  logic [15:0] m_data_out;
  logic        m_rd;
  logic        m_wr;
  logic        m_byte_op;
  logic        m_done;

  modport master (
    input  a_req, a_wr, a_byte, a_addr, a_wdata,
    output a_rdata, a_ack, a_err,
    input  b_req, b_wr, b_byte, b_addr, b_wdata,
    output b_rdata, b_ack, b_err,
    output m_addr, m_data_in, m_rd, m_wr, m_byte_op,
    input  m_data_out, m_done
  );

  modport slave (
    output a_req, a_wr, a_byte, a_addr, a_wdata,
    input  a_rdata, a_ack, a_err,
    output b_req, b_wr, b_byte, b_addr, b_wdata,
    input  b_rdata, b_ack, b_err,
    input  m_addr, m_data_in, m_rd, m_wr, m_byte_op,
    output m_data_out, m_done
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter -- round-robin arbiter sharing one SRAM controller between a
// CPU port (A) and a DMA port (B).
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : ram_arbiter_if.master (requester ports A/B + controller port)
//
// Parameter:
//   TIMEOUT : BUSY cycles without m_done before the access is aborted
//             with err=1.
//
// Access flow: IDLE grants one requester and launches the command, BUSY
// holds it until m_done (or timeout), RECOVER gives the controller its
// mandatory idle command cycle while the ack pulse is out.
module ram_arbiter #(
  parameter int TIMEOUT = 15
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.master bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // The counter only ever needs to hold 0..TIMEOUT-1: the cycle that would
  // bring it to TIMEOUT is the one that aborts.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_b_reg, last_b_next;   // 1 = B holds / last held the grant
  logic          m_rd_reg, m_rd_next;
  logic          m_wr_reg, m_wr_next;
  logic          m_byte_reg, m_byte_next;
  logic [17:0]   m_addr_reg, m_addr_next;
  logic [15:0]   m_wdata_reg, m_wdata_next;
  logic          a_ack_reg, a_ack_next;
  logic          b_ack_reg, b_ack_next;
  logic          a_err_reg, a_err_next;
  logic          b_err_reg, b_err_next;
  logic [15:0]   a_rdata_reg, a_rdata_next;
  logic [15:0]   b_rdata_reg, b_rdata_next;
  logic          pick_b;
  logic          finish;

  // B wins when it is alone, or when both ask and A was served last.
  assign pick_b = bus.b_req & (~bus.a_req | ~last_b_reg);
  // Access ends on completion or on the cycle that would hit TIMEOUT.
  assign finish = bus.m_done | (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      last_b_reg  <= 1'b1;
      m_rd_reg    <= 1'b0;
      m_wr_reg    <= 1'b0;
      m_byte_reg  <= 1'b0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      a_ack_reg   <= 1'b0;
      b_ack_reg   <= 1'b0;
      a_err_reg   <= 1'b0;
      b_err_reg   <= 1'b0;
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      last_b_reg  <= last_b_next;
      m_rd_reg    <= m_rd_next;
      m_wr_reg    <= m_wr_next;
      m_byte_reg  <= m_byte_next;
      m_addr_reg  <= m_addr_next;
      m_wdata_reg <= m_wdata_next;
      a_ack_reg   <= a_ack_next;
      b_ack_reg   <= b_ack_next;
      a_err_reg   <= a_err_next;
      b_err_reg   <= b_err_next;
      a_rdata_reg <= a_rdata_next;
      b_rdata_reg <= b_rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    last_b_next  = last_b_reg;
    m_rd_next    = m_rd_reg;
    m_wr_next    = m_wr_reg;
    m_byte_next  = m_byte_reg;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;
    a_ack_next   = 1'b0;
    b_ack_next   = 1'b0;
    a_err_next   = 1'b0;
    b_err_next   = 1'b0;
    a_rdata_next = a_rdata_reg;
    b_rdata_next = b_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (bus.a_req | bus.b_req) begin
          last_b_next  = pick_b;
          m_addr_next  = pick_b ? bus.b_addr  : bus.a_addr;
          m_wdata_next = pick_b ? bus.b_wdata : bus.a_wdata;
          m_byte_next  = pick_b ? bus.b_byte  : bus.a_byte;
          m_wr_next    = pick_b ? bus.b_wr    : bus.a_wr;
          m_rd_next    = ~(pick_b ? bus.b_wr : bus.a_wr);
          cnt_next     = '0;
          state_next   = BUSY;
        end
      end

      BUSY: begin
        if (finish) begin
          m_rd_next  = 1'b0;
          m_wr_next  = 1'b0;
          state_next = RECOVER;
          // A timeout returns zero data; a completed write leaves rdata alone.
          if (last_b_reg) begin
            b_ack_next = 1'b1;
            b_err_next = ~bus.m_done;
            if (!bus.m_done)   b_rdata_next = '0;
            else if (m_rd_reg) b_rdata_next = bus.m_data_out;
          end else begin
            a_ack_next = 1'b1;
            a_err_next = ~bus.m_done;
            if (!bus.m_done)   a_rdata_next = '0;
            else if (m_rd_reg) a_rdata_next = bus.m_data_out;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RECOVER: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign bus.m_rd      = m_rd_reg;
  assign bus.m_wr      = m_wr_reg;
  assign bus.m_byte_op = m_byte_reg;
  assign bus.m_addr    = m_addr_reg;
  assign bus.m_data_in = m_wdata_reg;
  assign bus.a_ack     = a_ack_reg;
  assign bus.b_ack     = b_ack_reg;
  assign bus.a_err     = a_err_reg;
  assign bus.b_err     = b_err_reg;
  assign bus.a_rdata   = a_rdata_reg;
  assign bus.b_rdata   = b_rdata_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if bus();

  ram_arbiter #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          use_b;
    bit          wr;
    bit          byt;
    logic [17:0] addr;
    logic [15:0] wdata;
    int          delay;   // cycles after first m_rd/m_wr cycle before m_done
    logic [15:0] dout;
    bit          early;   // spurious m_done in the IDLE and RECOVER cycles
    int          ack;     // expected ack cycle, req driven in cycle 0
    bit          err;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_wr = 0; bus.a_byte = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_wr = 0; bus.b_byte = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.m_done = 0; bus.m_data_out = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    idle_inputs();
    if (v.use_b) begin
      bus.b_req = 1; bus.b_wr = v.wr; bus.b_byte = v.byt; bus.b_addr = v.addr; bus.b_wdata = v.wdata;
    end else begin
      bus.a_req = 1; bus.a_wr = v.wr; bus.a_byte = v.byt; bus.a_addr = v.addr; bus.a_wdata = v.wdata;
    end
    bus.m_done = v.early;
    bus.m_data_out = 16'hDEAD;
    for (int k = 1; k <= v.ack + 1; k++) begin
      step();
      chk($sformatf("vec%0d m_rd k=%0d", idx, k), 64'(bus.m_rd), 64'(k < v.ack && !v.wr));
      chk($sformatf("vec%0d m_wr k=%0d", idx, k), 64'(bus.m_wr), 64'(k < v.ack && v.wr));
      if (k < v.ack)
        chk($sformatf("vec%0d fields k=%0d", idx, k), 64'({bus.m_addr, bus.m_data_in, bus.m_byte_op}),
            64'({v.addr, v.wdata, v.byt}));
      chk($sformatf("vec%0d acks k=%0d", idx, k), 64'({bus.a_ack, bus.b_ack}),
          64'((k == v.ack) ? (v.use_b ? 2'b01 : 2'b10) : 2'b00));
      if (k == v.ack) begin
        chk($sformatf("vec%0d err", idx), 64'(v.use_b ? bus.b_err : bus.a_err), 64'(v.err));
        chk($sformatf("vec%0d rdata", idx), 64'(v.use_b ? bus.b_rdata : bus.a_rdata), 64'(v.rdata));
        $display("vec %0d port=%s wr=%0d byte=%0d addr=%05h ack_cycle=%0d err=%0d rdata=%04h",
                 idx, v.use_b ? "B" : "A", v.wr, v.byt, v.addr, k,
                 v.use_b ? bus.b_err : bus.a_err, v.use_b ? bus.b_rdata : bus.a_rdata);
        bus.a_req = 0;
        bus.b_req = 0;
      end
      bus.m_done = (k == 1 + v.delay) || (v.early && k == v.ack);
      bus.m_data_out = (k == 1 + v.delay) ? v.dout : 16'($urandom);
    end
    bus.m_done = 0;
  endtask

  // Random-phase reference model state
  int          cyc, s_cyc, ack_cyc, next_free, dly, n_txn;
  bit          busy_m, own_b, own_wr, own_byte, last_b, in_win, at_ack;
  logic [17:0] own_addr;
  logic [15:0] own_wdata, own_dout, exp_ard, exp_brd;
  bit          rq[2], rwr[2], rbyte[2], compl[2];
  int          compl_cyc[2];
  logic [17:0] raddr[2];
  logic [15:0] rwd[2];

  initial begin
    //            use_b wr byt addr       wdata     dly  dout        early ack err rdata
    vecs[0] = '{1'b0, 1'b0, 1'b0, 18'o1000,  16'h0000, 1,  16'o123456, 1'b0, 3,  1'b0, 16'o123456};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 18'o1001,  16'h00A5, 1,  16'hFFFF,   1'b0, 3,  1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 18'h3FFFF, 16'h1111, 0,  16'hBEEF,   1'b1, 2,  1'b0, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 18'h00010, 16'hCAFE, 2,  16'h7777,   1'b0, 4,  1'b0, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 18'h12345, 16'h0000, 99, 16'h9999,   1'b1, 16, 1'b1, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 18'h00002, 16'h0000, 14, 16'h1234,   1'b0, 16, 1'b0, 16'h1234};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 18'h20000, 16'h8001, 3,  16'h4444,   1'b1, 5,  1'b0, 16'h1234};

    // Reset with every input active: reset must dominate.
    idle_inputs();
    bus.a_req = 1; bus.b_req = 1; bus.m_done = 1; bus.a_addr = 18'h3FFFF; bus.a_wdata = 16'hFFFF;
    step();
    step();
    chk("reset m_rd/m_wr/byte", 64'({bus.m_rd, bus.m_wr, bus.m_byte_op}), 64'(0));
    chk("reset m_addr", 64'(bus.m_addr), 64'(0));
    chk("reset m_data_in", 64'(bus.m_data_in), 64'(0));
    chk("reset acks/errs", 64'({bus.a_ack, bus.b_ack, bus.a_err, bus.b_err}), 64'(0));
    chk("reset rdata", 64'({bus.a_rdata, bus.b_rdata}), 64'(0));

    // Tie right after reset: held requests alternate A, B, A, B.
    reset = 0;
    idle_inputs();
    bus.a_req = 1; bus.a_wr = 0; bus.a_addr = 18'h00AAA;
    bus.b_req = 1; bus.b_wr = 1; bus.b_addr = 18'h00BBB; bus.b_wdata = 16'h5555;
    for (int k = 1; k <= 16; k++) begin
      int  ph;
      bit  exp_b;
      step();
      ph = (k - 1) % 4;
      exp_b = (((k - 1) / 4) % 2) == 1;
      if (ph == 0) begin
        chk($sformatf("tie m_addr k=%0d", k), 64'(bus.m_addr), 64'(exp_b ? 18'h00BBB : 18'h00AAA));
        chk($sformatf("tie rd/wr k=%0d", k), 64'({bus.m_rd, bus.m_wr}), 64'(exp_b ? 2'b01 : 2'b10));
      end
      if (ph == 2) begin
        chk($sformatf("tie acks k=%0d", k), 64'({bus.a_ack, bus.b_ack}), 64'(exp_b ? 2'b01 : 2'b10));
        if (!exp_b) chk($sformatf("tie a_rdata k=%0d", k), 64'(bus.a_rdata), 64'(16'h1000 + k - 1));
        $display("tie access k=%0d granted=%s", k, bus.b_ack ? "B" : "A");
      end
      if (ph >= 2) chk($sformatf("tie gap k=%0d", k), 64'({bus.m_rd, bus.m_wr}), 64'(0));
      if (ph == 3) chk($sformatf("tie no ack k=%0d", k), 64'({bus.a_ack, bus.b_ack}), 64'(0));
      bus.m_done = (ph == 1);
      bus.m_data_out = 16'(16'h1000 + k);
      if (k == 16) begin
        bus.a_req = 0;
        bus.b_req = 0;
      end
    end

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset in the middle of an A write, then a tie that A must win.
    idle_inputs();
    bus.a_req = 1; bus.a_wr = 1; bus.a_addr = 18'h0ABCD; bus.a_wdata = 16'h4321;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("midrst m_wr k=%0d", k), 64'(bus.m_wr), 64'(1));
    end
    reset = 1;
    bus.m_done = 1;
    step();
    chk("midrst m_rd/m_wr", 64'({bus.m_rd, bus.m_wr}), 64'(0));
    chk("midrst acks", 64'({bus.a_ack, bus.b_ack}), 64'(0));
    chk("midrst rdata", 64'({bus.a_rdata, bus.b_rdata}), 64'(0));
    reset = 0;
    bus.m_done = 0;
    bus.a_wr = 0; bus.a_addr = 18'h01111;
    bus.b_req = 1; bus.b_wr = 0; bus.b_addr = 18'h02222;
    step();
    chk("midrst regrant m_addr", 64'(bus.m_addr), 64'(18'h01111));
    chk("midrst regrant m_rd", 64'({bus.m_rd, bus.m_wr}), 64'(2'b10));
    chk("midrst regrant acks", 64'({bus.a_ack, bus.b_ack}), 64'(0));
    bus.m_done = 1;
    bus.m_data_out = 16'h5A5A;
    step();
    chk("midrst ack", 64'({bus.a_ack, bus.b_ack, bus.a_err}), 64'(3'b100));
    chk("midrst a_rdata", 64'(bus.a_rdata), 64'(16'h5A5A));
    $display("post-reset access granted=A rdata=%04h", bus.a_rdata);

    // Randomized traffic against the transaction-level model.
    reset = 1;
    idle_inputs();
    step();
    step();
    reset = 0;
    cyc = 0; next_free = 0; busy_m = 0; last_b = 1; n_txn = 0;
    exp_ard = '0; exp_brd = '0;
    s_cyc = 0; ack_cyc = 0; dly = 0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 0; compl[p] = 0; compl_cyc[p] = 0; rwr[p] = 0; rbyte[p] = 0; raddr[p] = '0; rwd[p] = '0;
    end
    for (int it = 0; it < 3000; it++) begin
      int idx;
      int r;
      step();
      cyc++;
      // Requests seen in an IDLE cycle start an access in the next cycle.
      if (!busy_m && cyc - 1 >= next_free && (rq[0] || rq[1])) begin
        if (rq[0] && rq[1]) own_b = !last_b;
        else                own_b = rq[1];
        last_b = own_b;
        idx = own_b ? 1 : 0;
        own_wr = rwr[idx]; own_byte = rbyte[idx]; own_addr = raddr[idx]; own_wdata = rwd[idx];
        r = int'($urandom_range(0, 15));
        if (!own_wr && r == 0) dly = TO + 10;
        else if (r == 1)       dly = TO - 1;
        else                   dly = int'($urandom_range(0, 3));
        own_dout = 16'($urandom);
        s_cyc = cyc;
        ack_cyc = s_cyc + ((dly < TO) ? dly + 1 : TO);
        busy_m = 1;
      end
      in_win = busy_m && cyc < ack_cyc;
      at_ack = busy_m && cyc == ack_cyc;
      chk("rnd m_rd", 64'(bus.m_rd), 64'(in_win && !own_wr));
      chk("rnd m_wr", 64'(bus.m_wr), 64'(in_win && own_wr));
      if (in_win)
        chk("rnd fields", 64'({bus.m_addr, bus.m_data_in, bus.m_byte_op}), 64'({own_addr, own_wdata, own_byte}));
      if (at_ack) begin
        if (own_b) begin
          if (dly >= TO)    exp_brd = '0;
          else if (!own_wr) exp_brd = own_dout;
        end else begin
          if (dly >= TO)    exp_ard = '0;
          else if (!own_wr) exp_ard = own_dout;
        end
      end
      chk("rnd acks", 64'({bus.a_ack, bus.b_ack}), 64'({at_ack && !own_b, at_ack && own_b}));
      if (at_ack) chk("rnd err", 64'(own_b ? bus.b_err : bus.a_err), 64'(dly >= TO));
      chk("rnd rdata", 64'({bus.a_rdata, bus.b_rdata}), 64'({exp_ard, exp_brd}));
      if (at_ack) begin
        n_txn++;
        $display("rnd txn %0d cyc=%0d port=%s wr=%0d addr=%05h delay=%0d err=%0d",
                 n_txn, cyc, own_b ? "B" : "A", own_wr, own_addr, dly, own_b ? bus.b_err : bus.a_err);
        busy_m = 0;
        next_free = cyc + 1;
        idx = own_b ? 1 : 0;
        compl[idx] = 1;
        compl_cyc[idx] = cyc;
      end
      // Controller: one done pulse per access; stray pulses only outside BUSY.
      if (in_win) begin
        bus.m_done = (cyc == s_cyc + dly);
        bus.m_data_out = bus.m_done ? own_dout : 16'($urandom);
      end else begin
        bus.m_done = ($urandom_range(0, 7) == 0);
        bus.m_data_out = 16'($urandom);
      end
      // Requesters: hold until ack, then drop or re-request the cycle after.
      for (int p = 0; p < 2; p++) begin
        if (rq[p] && compl[p] && cyc > compl_cyc[p]) begin
          compl[p] = 0;
          rq[p] = 0;
        end
        if (!rq[p] && $urandom_range(0, 2) == 0) begin
          rq[p] = 1;
          rwr[p] = 1'($urandom);
          rbyte[p] = 1'($urandom);
          raddr[p] = 18'($urandom);
          rwd[p] = 16'($urandom);
        end
      end
      bus.a_req = rq[0]; bus.a_wr = rwr[0]; bus.a_byte = rbyte[0]; bus.a_addr = raddr[0]; bus.a_wdata = rwd[0];
      bus.b_req = rq[1]; bus.b_wr = rwr[1]; bus.b_byte = rbyte[1]; bus.b_addr = raddr[1]; bus.b_wdata = rwd[1];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
